chunk_source_scheduler: RTL and testbench

- Shares one byte-serial chunk assembler (384-byte / 3072-bit chunks) between NUM_SRC camera NAL byte sources.
- Round-robin grant, held for one whole chunk, so every chunk carries bytes from a single source.
- Pads short chunks when a NAL ends early or the owning source stalls too long; tags output with the source id.
- Sits between the per-camera NAL byte FIFOs and the chunk assembler's bitstream_data/bitstream_valid input.

---
 rtl/chunk_sched_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/chunk_source_scheduler.sv | 143 ++++++++++++++
 tb/tb_chunk_source_scheduler.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chunk_sched_pkg.sv
// Shared types and defaults for the chunk source scheduler.
package chunk_sched_pkg;

    localparam int unsigned CHUNK_BYTES_DEF  = 384;
    localparam int unsigned IDLE_TIMEOUT_DEF = 64;
    localparam logic [7:0]  PAD_BYTE_DEF     = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        PAD
    } sched_state_t;

    // Index following idx in a ring of n entries.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_SRC = 4,
    localparam int unsigned IW = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_SRC-1:0] gnt_onehot,
    output logic [IW-1:0]      gnt_idx,
    output logic               gnt_valid
);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        sum       = '0;
        cand      = '0;
        // Walk from the far end so the nearest requester to ptr is written last.
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (IW + 1)'(k);
            if (sum >= (IW + 1)'(NUM_SRC)) begin
                sum = sum - (IW + 1)'(NUM_SRC);
            end
            cand = sum[IW-1:0];
            if (req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
        gnt_onehot = gnt_valid ? (NUM_SRC'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/chunk_source_scheduler.sv
// Shares one byte-serial chunk assembler between NUM_SRC NAL byte sources,
// one whole chunk per grant, padding chunks cut short by src_last or a stall.
module chunk_source_scheduler
    import chunk_sched_pkg::*;
#(
    parameter int unsigned NUM_SRC      = 4,
    parameter int unsigned CHUNK_BYTES  = CHUNK_BYTES_DEF,
    parameter int unsigned IDLE_TIMEOUT = IDLE_TIMEOUT_DEF,
    parameter logic [7:0]  PAD_BYTE     = PAD_BYTE_DEF,
    localparam int unsigned IW = $clog2(NUM_SRC)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_SRC*8-1:0] src_data,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic [NUM_SRC-1:0]   src_last,
    output logic [NUM_SRC-1:0]   src_ready,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    output logic [IW-1:0]        out_src_id,
    output logic                 chunk_start,
    output logic                 chunk_done,
    output logic                 chunk_padded,
    output logic                 timeout_err,
    output logic                 busy
);

    localparam int unsigned CW = $clog2(CHUNK_BYTES);
    localparam int unsigned TW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(CHUNK_BYTES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(IDLE_TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_SAT  = TW'(IDLE_TIMEOUT);

    sched_state_t        state;
    logic [IW-1:0]       grant;
    logic [NUM_SRC-1:0]  grant_oh;
    logic [IW-1:0]       rr_ptr;
    logic [CW-1:0]       byte_cnt;
    logic [TW-1:0]       idle_cnt;

    logic [NUM_SRC-1:0]  arb_onehot;
    logic [IW-1:0]       arb_idx;
    logic                arb_valid;

    logic [7:0]          sel_data;
    logic                sel_valid;
    logic                sel_last;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC)
    ) u_arb (
        .req        (src_valid),
        .ptr        (rr_ptr),
        .gnt_onehot (arb_onehot),
        .gnt_idx    (arb_idx),
        .gnt_valid  (arb_valid)
    );

    assign sel_data  = src_data[{grant, 3'b000} +: 8];
    assign sel_valid = src_valid[grant];
    assign sel_last  = src_last[grant];

    // Ready depends only on state and the registered grant, never on valid.
    assign src_ready = (state == XFER) ? grant_oh : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            grant        <= '0;
            grant_oh     <= '0;
            rr_ptr       <= '0;
            byte_cnt     <= '0;
            idle_cnt     <= '0;
            out_data     <= 8'h00;
            out_valid    <= 1'b0;
            out_src_id   <= '0;
            chunk_start  <= 1'b0;
            chunk_done   <= 1'b0;
            chunk_padded <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            out_valid   <= 1'b0;
            chunk_start <= 1'b0;
            chunk_done  <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    chunk_padded <= 1'b0;
                    if (arb_valid) begin
                        grant      <= arb_idx;
                        grant_oh   <= arb_onehot;
                        out_src_id <= arb_idx;
                        rr_ptr     <= IW'(rr_next(32'(arb_idx), NUM_SRC));
                        idle_cnt   <= '0;
                        state      <= XFER;
                    end
                end
                XFER: begin
                    if (sel_valid) begin
                        // An accept always beats a coincident timeout.
                        out_data    <= sel_data;
                        out_valid   <= 1'b1;
                        chunk_start <= (byte_cnt == '0);
                        idle_cnt    <= '0;
                        if (byte_cnt == LAST_CNT) begin
                            chunk_done <= 1'b1;
                            byte_cnt   <= '0;
                            state      <= IDLE;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                            if (sel_last) begin
                                state <= PAD;
                            end
                        end
                    end else if (idle_cnt == TMO_LAST) begin
                        idle_cnt    <= TMO_SAT;
                        timeout_err <= 1'b1;
                        state       <= PAD;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                PAD: begin
                    out_data     <= PAD_BYTE;
                    out_valid    <= 1'b1;
                    chunk_padded <= 1'b1;
                    chunk_start  <= (byte_cnt == '0);
                    idle_cnt     <= '0;
                    if (byte_cnt == LAST_CNT) begin
                        chunk_done <= 1'b1;
                        byte_cnt   <= '0;
                        state      <= IDLE;
                    end else begin
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chunk_source_scheduler.sv
// Scoreboard bench: per-source chunk model merged round-robin into an expected byte stream.
module tb_chunk_source_scheduler;

    localparam int N   = 4;
    localparam int CB  = 384;
    localparam int TMO = 64;
    localparam int LONG_STALL = 70;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N*8-1:0] src_data;
    logic [N-1:0]   src_valid;
    logic [N-1:0]   src_last;
    logic [N-1:0]   src_ready;
    logic [7:0]     out_data;
    logic           out_valid;
    logic [1:0]     out_src_id;
    logic           chunk_start;
    logic           chunk_done;
    logic           chunk_padded;
    logic           timeout_err;
    logic           busy;

    always #5 clk = ~clk;

    chunk_source_scheduler #(
        .NUM_SRC      (N),
        .CHUNK_BYTES  (CB),
        .IDLE_TIMEOUT (TMO),
        .PAD_BYTE     (8'h00)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .src_data     (src_data),
        .src_valid    (src_valid),
        .src_last     (src_last),
        .src_ready    (src_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_src_id   (out_src_id),
        .chunk_start  (chunk_start),
        .chunk_done   (chunk_done),
        .chunk_padded (chunk_padded),
        .timeout_err  (timeout_err),
        .busy         (busy)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       ghost;
        logic [7:0] stall;
    } item_t;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] src;
        logic       start;
        logic       done;
        logic       padded;
    } exp_t;

    item_t drv_q[N][$];
    exp_t  part_q[N][$];
    exp_t  chunk_q[N][$];
    exp_t  exp_q[$];

    int     n_chk = 0;
    int     n_fail = 0;
    int     tmo_exp = 0;
    int     tmo_seen = 0;
    int     model_ptr = 0;
    int     obs_cnt = 0;
    longint cyc = 0;
    longint last_valid_cyc = 0;
    longint done_cyc = 0;
    bit     have_byte = 0;
    bit     have_done = 0;
    bit     gap_chk = 0;
    int     stall_cnt[N];
    bit     ghost_on[N];
    logic [N-1:0] acc;
    exp_t   mon_got;
    exp_t   mon_exp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Pad the open chunk of source s to CB bytes and file it as complete.
    task automatic finish_chunk(input int s);
        exp_t e;
        while (part_q[s].size() < CB) begin
            e = {8'h00, 2'(s), (part_q[s].size() == 0), 1'b0, 1'b1};
            part_q[s].push_back(e);
        end
        e = part_q[s][CB-1];
        e.done = 1'b1;
        part_q[s][CB-1] = e;
        for (int j = 0; j < CB; j++) chunk_q[s].push_back(part_q[s][j]);
        part_q[s].delete();
    endtask

    // mode: 0 none, 1 short stall after this byte, 2 stall long enough to time out.
    task automatic push_item(input int s, input logic [7:0] d, input logic last, input int mode);
        item_t it;
        exp_t  e;
        int    len;
        len = part_q[s].size();
        e = {d, 2'(s), (len == 0), 1'b0, 1'b0};
        part_q[s].push_back(e);
        len++;
        it = {d, last, 1'b0, 8'd0};
        if (len == CB) begin
            finish_chunk(s);
        end else if (last) begin
            finish_chunk(s);
        end else if (mode == 2 && len <= 300) begin
            it.stall = 8'(LONG_STALL);
            tmo_exp++;
            finish_chunk(s);
        end else if (mode == 1) begin
            it.stall = 8'($urandom_range(1, 30));
        end
        drv_q[s].push_back(it);
    endtask

    // Source asserts valid for the arbitration cycle only, then vanishes.
    task automatic push_ghost(input int s);
        item_t it;
        it = {8'hEE, 1'b0, 1'b1, 8'd0};
        drv_q[s].push_back(it);
        tmo_exp++;
        finish_chunk(s);
    endtask

    task automatic schedule();
        bit found;
        int s;
        do begin
            found = 0;
            for (int k = 0; k < N && !found; k++) begin
                s = (model_ptr + k) % N;
                if (chunk_q[s].size() > 0) begin
                    for (int j = 0; j < CB; j++) exp_q.push_back(chunk_q[s].pop_front());
                    model_ptr = (s + 1) % N;
                    found = 1;
                end
            end
        end while (found);
    endtask

    function automatic bit drv_pending();
        for (int s = 0; s < N; s++) if (drv_q[s].size() > 0) return 1;
        return 0;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        exp_q.delete();
        for (int s = 0; s < N; s++) begin
            part_q[s].delete();
            chunk_q[s].delete();
        end
        model_ptr = 0;
        tmo_exp = 0;
        tmo_seen = 0;
        have_byte = 0;
        have_done = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_phase(input string name);
        int budget;
        budget = 20000;
        while ((exp_q.size() > 0 || drv_pending() || busy) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk({name, "_drained"}, 64'(budget > 0), 64'd1);
        chk({name, "_timeouts"}, 64'(tmo_seen), 64'(tmo_exp));
        repeat (3) @(negedge clk);
    endtask

    // Source drivers: pop on handshake, honour per-item stalls.
    initial begin
        item_t h;
        src_valid = '0;
        src_last  = '0;
        src_data  = '0;
        acc       = '0;
        for (int s = 0; s < N; s++) begin
            stall_cnt[s] = 0;
            ghost_on[s]  = 0;
        end
        forever begin
            @(negedge clk);
            acc = src_valid & src_ready;
            @(posedge clk);
            #1;
            for (int s = 0; s < N; s++) begin
                if (reset) begin
                    drv_q[s].delete();
                    stall_cnt[s] = 0;
                    ghost_on[s]  = 0;
                    src_valid[s] = 1'b0;
                    src_last[s]  = 1'b0;
                end else begin
                    if (acc[s]) begin
                        h = drv_q[s].pop_front();
                        stall_cnt[s] = int'(h.stall);
                    end else if (ghost_on[s]) begin
                        h = drv_q[s].pop_front();
                        ghost_on[s]  = 0;
                        stall_cnt[s] = LONG_STALL;
                    end
                    if (stall_cnt[s] > 0) begin
                        stall_cnt[s]--;
                        src_valid[s] = 1'b0;
                        src_last[s]  = 1'b0;
                    end else if (drv_q[s].size() > 0) begin
                        src_valid[s]        = 1'b1;
                        src_data[s*8 +: 8]  = drv_q[s][0].data;
                        src_last[s]         = drv_q[s][0].last;
                        ghost_on[s]         = drv_q[s][0].ghost;
                    end else begin
                        src_valid[s] = 1'b0;
                        src_last[s]  = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: compare every output byte against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (out_valid) begin
                    mon_got = {out_data, out_src_id, chunk_start, chunk_done, chunk_padded};
                    chk("out_byte_expected", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) begin
                        mon_exp = exp_q.pop_front();
                        chk("out_byte", 64'(mon_got), 64'(mon_exp));
                    end
                    obs_cnt++;
                    if (gap_chk && chunk_start && have_done)
                        chk("idle_gap", 64'(cyc - done_cyc), 64'd2);
                    last_valid_cyc = cyc;
                    have_byte = 1;
                    if (chunk_done) begin
                        done_cyc  = cyc;
                        have_done = 1;
                        have_byte = 0;
                    end
                end
                if (timeout_err) begin
                    tmo_seen++;
                    if (have_byte) chk("timeout_latency", 64'(cyc - last_valid_cyc), 64'(TMO));
                end
            end
        end
    end

    initial begin
        int budget;
        int obs0;
        int r;
        int target;
        int mode;

        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_src_ready", 64'(src_ready), 64'd0);
        chk("rst_flags", 64'({chunk_start, chunk_done, chunk_padded, timeout_err, out_src_id}), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single source, 384 contiguous bytes.
        for (int i = 0; i < CB; i++) push_item(1, 8'(i), 1'b0, 0);
        schedule();
        @(posedge clk); #2;
        chk("arb_cycle_ready", 64'(src_ready), 64'd0);
        @(posedge clk); #2;
        chk("grant_ready", 64'(src_ready), 64'b0010);
        chk("grant_busy", 64'(busy), 64'd1);
        chk("grant_src_id", 64'(out_src_id), 64'd1);
        @(posedge clk); #2;
        chk("first_byte_latency", 64'({out_valid, chunk_start, out_data}), 64'({1'b1, 1'b1, 8'h00}));
        run_phase("single_src");

        // Two continuous sources alternate 0,2,0,2.
        do_reset();
        gap_chk = 1;
        for (int i = 0; i < 2 * CB; i++) begin
            push_item(0, 8'($urandom), 1'b0, 0);
            push_item(2, 8'($urandom), 1'b0, 0);
        end
        schedule();
        run_phase("two_src");
        gap_chk = 0;

        // Short NAL: 100 bytes then pad.
        for (int i = 0; i < 100; i++) push_item(3, 8'($urandom), (i == 99), 0);
        schedule();
        run_phase("short_nal");

        // Stall timeout after 10 bytes while source 1 waits.
        for (int i = 0; i < 10; i++) push_item(0, 8'($urandom), 1'b0, (i == 9) ? 2 : 0);
        for (int i = 0; i < CB; i++) push_item(0, 8'($urandom), 1'b0, 0);
        for (int i = 0; i < CB; i++) push_item(1, 8'($urandom), 1'b0, 0);
        schedule();
        run_phase("timeout");

        // src_last on the final byte of a full chunk.
        for (int i = 0; i < CB; i++) push_item(2, 8'($urandom), (i == CB - 1), 0);
        schedule();
        run_phase("last_on_full");

        // Reset in the middle of a chunk.
        for (int i = 0; i < 2 * CB; i++) push_item(0, 8'($urandom), 1'b0, 0);
        schedule();
        obs0 = obs_cnt;
        budget = 2000;
        while (obs_cnt - obs0 < 200 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        chk("reached_byte_200", 64'(obs_cnt - obs0 >= 200), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_out", 64'({out_valid, out_data, out_src_id}), 64'd0);
        chk("midrst_flags", 64'({chunk_start, chunk_done, chunk_padded, timeout_err}), 64'd0);
        chk("midrst_busy_ready", 64'({busy, src_ready}), 64'd0);
        do_reset();
        for (int i = 0; i < CB; i++) begin
            push_item(0, 8'($urandom), 1'b0, 0);
            push_item(3, 8'($urandom), 1'b0, 0);
        end
        schedule();
        @(posedge clk);
        @(posedge clk); #2;
        chk("post_rst_grant", 64'({out_src_id, src_ready}), 64'({2'd0, 4'b0001}));
        run_phase("after_reset");

        // Granted source vanishes before its first byte: full pad chunk.
        push_ghost(2);
        schedule();
        run_phase("ghost");

        // Randomised traffic on all sources.
        for (int s = 0; s < N; s++) begin
            r = $urandom_range(1, 2);
            for (int c = 0; c < r; c++) begin
                target = chunk_q[s].size() + CB;
                while (chunk_q[s].size() < target) begin
                    mode = $urandom_range(0, 199);
                    mode = (mode < 10) ? 1 : (mode == 199) ? 2 : 0;
                    push_item(s, 8'($urandom), ($urandom_range(0, 199) == 0), mode);
                end
            end
        end
        schedule();
        run_phase("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
